// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM data-memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic LOW_HALF  = 1'b0;
    localparam logic HIGH_HALF = 1'b1;

    localparam int DEFAULT_ACCESS_CYCLES = 2;
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_access_timer.sv
// Per-phase cycle counter: counts while start is high and wraps to zero
// after the last cycle of a phase so the next half starts fresh.
import mem_ctrl_pkg::*;

module sram_access_timer #(
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic last_cycle,
    output logic phase_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= last_cycle ? '0 : count + 1'b1;
        end
    end

    assign last_cycle = (count == LAST);
    assign phase_done = start & last_cycle;

endmodule

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit load/store into two timed 16-bit SRAM accesses (low half
// first) and freezes the pipeline until the access has completed.
import mem_ctrl_pkg::*;

module sram_mem_controller #(
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
    parameter int SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    state_t             state, next_state;
    logic [SRAM_AW-2:0] addr_q;
    logic [31:0]        data_q;
    logic               write_q;
    logic [15:0]        low_q;
    logic               active;
    logic               accept;
    logic               last_cycle;
    logic               phase_done;
    logic               unused_bits;

    assign unused_bits = ^{address[31:SRAM_AW+1], address[1:0]};

    assign active = (state == LOW) || (state == HIGH);
    assign accept = (state == IDLE) && (rd_en || wr_en);

    sram_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (active),
        .clear     (!active),
        .last_cycle(last_cycle),
        .phase_done(phase_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (rd_en || wr_en) next_state = LOW;
            LOW:  if (phase_done) next_state = HIGH;
            HIGH: if (phase_done) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The low half is parked in low_q so read_data only changes when ready rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            low_q     <= '0;
            read_data <= '0;
        end else begin
            if (accept) begin
                addr_q  <= address[SRAM_AW:2];
                data_q  <= write_data;
                write_q <= wr_en;
            end
            if (state == LOW && !write_q && phase_done) begin
                low_q <= sram_dq_in;
            end
            if (state == HIGH && !write_q && phase_done) begin
                read_data <= {sram_dq_in, low_q};
            end
        end
    end

    // SRAM pins decode only flops; WE rises on the last cycle so the address never moves under WE low.
    always_comb begin
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        if (state == LOW) begin
            sram_addr = {addr_q, LOW_HALF};
            if (write_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = data_q[15:0];
                sram_we_n   = last_cycle;
            end
        end else if (state == HIGH) begin
            sram_addr = {addr_q, HIGH_HALF};
            if (write_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = data_q[31:16];
                sram_we_n   = last_cycle;
            end
        end
    end

    assign ready  = (state == DONE);
    assign freeze = (rd_en | wr_en) & ~ready;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: one instance with ACCESS_CYCLES=2
// and one with ACCESS_CYCLES=4 share the same stimulus.
module tb_sram_mem_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [15:0] sram_dq_in;

    logic [31:0] read_data;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;

    logic [31:0] read_data4;
    logic        ready4;
    logic        freeze4;
    logic [17:0] sram_addr4;
    logic        sram_we_n4;
    logic [15:0] sram_dq_out4;
    logic        sram_dq_oe4;

    int numChecks = 0;
    int numFails  = 0;

    sram_mem_controller #(.ACCESS_CYCLES(2), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .freeze(freeze), .sram_addr(sram_addr),
        .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    sram_mem_controller #(.ACCESS_CYCLES(4), .SRAM_AW(18)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data4),
        .ready(ready4), .freeze(freeze4), .sram_addr(sram_addr4),
        .sram_we_n(sram_we_n4), .sram_dq_out(sram_dq_out4),
        .sram_dq_oe(sram_dq_oe4), .sram_dq_in(sram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [31:0] expReady, input logic [31:0] expFreeze,
                              input logic [31:0] expWeN, input logic [31:0] expOe,
                              input logic [31:0] expAddr, input logic [31:0] expDq);
        checkOutput({tag, ".ready"},  32'(ready),       expReady);
        checkOutput({tag, ".freeze"}, 32'(freeze),      expFreeze);
        checkOutput({tag, ".we_n"},   32'(sram_we_n),   expWeN);
        checkOutput({tag, ".oe"},     32'(sram_dq_oe),  expOe);
        checkOutput({tag, ".addr"},   32'(sram_addr),   expAddr);
        checkOutput({tag, ".dq_out"}, 32'(sram_dq_out), expDq);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [15:0] dq);
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        sram_dq_in = dq;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0; sram_dq_in = '0;
        #2;
        $display("[TB] reset values");
        checkCycle("rst", 0, 0, 1, 0, 0, 0);
        checkOutput("rst.read_data", read_data, 32'h0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("[TB] store 0xDEADBEEF to 0x100");
        applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 16'h0);
        checkCycle("st.c0", 0, 1, 1, 0, 0, 0);
        nextCycle(); applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 16'h0);
        checkCycle("st.c1", 0, 1, 0, 1, 'h080, 'hBEEF);
        nextCycle(); applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 16'h0);
        checkCycle("st.c2", 0, 1, 1, 1, 'h080, 'hBEEF);
        nextCycle(); applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 16'h0);
        checkCycle("st.c3", 0, 1, 0, 1, 'h081, 'hDEAD);
        nextCycle(); applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 16'h0);
        checkCycle("st.c4", 0, 1, 1, 1, 'h081, 'hDEAD);
        nextCycle(); applyStimulus(1, 0, 32'h100, 32'hDEADBEEF, 16'h0);
        checkCycle("st.c5", 1, 0, 1, 0, 0, 0);
        checkOutput("st.read_data", read_data, 32'h0);
        nextCycle(); applyStimulus(0, 0, 32'h0, 32'h0, 16'h0);
        checkCycle("st.idle", 0, 0, 1, 0, 0, 0);

        $display("[TB] load from 0x100");
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'hFFFF);
        checkCycle("ld.c0", 0, 1, 1, 0, 0, 0);
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'h5555);
        checkCycle("ld.c1", 0, 1, 1, 0, 'h080, 0);
        checkOutput("ld.c1.read_data", read_data, 32'h0);
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'h1234);
        checkCycle("ld.c2", 0, 1, 1, 0, 'h080, 0);
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'h7777);
        checkCycle("ld.c3", 0, 1, 1, 0, 'h081, 0);
        checkOutput("ld.c3.read_data", read_data, 32'h0);
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'hABCD);
        checkCycle("ld.c4", 0, 1, 1, 0, 'h081, 0);
        checkOutput("ld.c4.read_data", read_data, 32'h0);
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'h0000);
        checkCycle("ld.c5", 1, 0, 1, 0, 0, 0);
        checkOutput("ld.read_data", read_data, 32'hABCD1234);
        nextCycle(); applyStimulus(0, 0, 32'h0, 32'h0, 16'h0);

        $display("[TB] simultaneous write and read");
        nextCycle(); applyStimulus(1, 1, 32'h200, 32'h55AA33CC, 16'h9999);
        checkCycle("wr.c0", 0, 1, 1, 0, 0, 0);
        nextCycle(); applyStimulus(1, 1, 32'h200, 32'h55AA33CC, 16'h9999);
        checkCycle("wr.c1", 0, 1, 0, 1, 'h100, 'h33CC);
        nextCycle(); applyStimulus(1, 1, 32'h200, 32'h55AA33CC, 16'h9999);
        checkCycle("wr.c2", 0, 1, 1, 1, 'h100, 'h33CC);
        nextCycle(); applyStimulus(1, 1, 32'h200, 32'h55AA33CC, 16'h9999);
        checkCycle("wr.c3", 0, 1, 0, 1, 'h101, 'h55AA);
        nextCycle(); applyStimulus(1, 1, 32'h200, 32'h55AA33CC, 16'h9999);
        checkCycle("wr.c4", 0, 1, 1, 1, 'h101, 'h55AA);
        nextCycle(); applyStimulus(1, 1, 32'h200, 32'h55AA33CC, 16'h9999);
        checkCycle("wr.c5", 1, 0, 1, 0, 0, 0);
        checkOutput("wr.read_data", read_data, 32'hABCD1234);
        nextCycle(); applyStimulus(0, 0, 32'h0, 32'h0, 16'h0);

        $display("[TB] back-to-back load then store");
        nextCycle(); applyStimulus(0, 1, 32'h8, 32'h0, 16'h0);
        checkCycle("bb.c0", 0, 1, 1, 0, 0, 0);
        nextCycle(); applyStimulus(0, 1, 32'h8, 32'h0, 16'h0);
        checkCycle("bb.c1", 0, 1, 1, 0, 'h004, 0);
        nextCycle(); applyStimulus(0, 1, 32'h8, 32'h0, 16'h1111);
        nextCycle(); applyStimulus(0, 1, 32'h8, 32'h0, 16'h0);
        checkCycle("bb.c3", 0, 1, 1, 0, 'h005, 0);
        nextCycle(); applyStimulus(0, 1, 32'h8, 32'h0, 16'h2222);
        nextCycle(); applyStimulus(0, 1, 32'h8, 32'h0, 16'h0);
        checkCycle("bb.c5", 1, 0, 1, 0, 0, 0);
        checkOutput("bb.read_data", read_data, 32'h22221111);
        nextCycle(); applyStimulus(1, 0, 32'h10, 32'hCAFEF00D, 16'h0);
        checkCycle("bb.c6", 0, 1, 1, 0, 0, 0);
        nextCycle(); applyStimulus(1, 0, 32'h10, 32'hCAFEF00D, 16'h0);
        checkCycle("bb.c7", 0, 1, 0, 1, 'h008, 'hF00D);
        for (int i = 0; i < 4; i++) begin
            nextCycle(); applyStimulus(1, 0, 32'h10, 32'hCAFEF00D, 16'h0);
        end
        checkCycle("bb.c11", 1, 0, 1, 0, 0, 0);
        checkOutput("bb.read_data2", read_data, 32'h22221111);
        nextCycle(); applyStimulus(0, 0, 32'h0, 32'h0, 16'h0);

        $display("[TB] reset in the middle of a write");
        nextCycle(); applyStimulus(1, 0, 32'h40, 32'h12345678, 16'h0);
        checkCycle("rw.c0", 0, 1, 1, 0, 0, 0);
        nextCycle(); applyStimulus(1, 0, 32'h40, 32'h12345678, 16'h0);
        checkCycle("rw.c1", 0, 1, 0, 1, 'h020, 'h5678);
        rst = 1'b1;
        #1;
        checkCycle("rw.rst", 0, 1, 1, 0, 0, 0);
        checkOutput("rw.read_data", read_data, 32'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkCycle("rw.rel", 0, 1, 1, 0, 0, 0);
        wr_en = 1'b0;
        #1;
        checkOutput("rw.freeze_norq", 32'(freeze), 32'h0);
        nextCycle();
        checkCycle("rw.idle", 0, 0, 1, 0, 0, 0);

        $display("[TB] ACCESS_CYCLES=4 load");
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'h0F0F);
        checkOutput("a4.c0.freeze", 32'(freeze4), 32'h1);
        for (int c = 1; c <= 8; c++) begin
            nextCycle();
            applyStimulus(0, 1, 32'h100, 32'h0, (c == 4) ? 16'h5678 : (c == 8) ? 16'h9ABC : 16'hF0F0);
            if (c == 4) checkOutput("a4.c4.addr", 32'(sram_addr4), 32'h080);
            if (c == 5) checkOutput("a4.c5.addr", 32'(sram_addr4), 32'h081);
            checkOutput("a4.we_n", 32'(sram_we_n4), 32'h1);
            checkOutput("a4.oe", 32'(sram_dq_oe4), 32'h0);
        end
        checkOutput("a4.c8.ready", 32'(ready4), 32'h0);
        checkOutput("a4.c8.freeze", 32'(freeze4), 32'h1);
        checkOutput("a4.c8.read_data", read_data4, 32'h0);
        nextCycle(); applyStimulus(0, 1, 32'h100, 32'h0, 16'h0);
        checkOutput("a4.c9.ready", 32'(ready4), 32'h1);
        checkOutput("a4.c9.freeze", 32'(freeze4), 32'h0);
        checkOutput("a4.read_data", read_data4, 32'h9ABC5678);
        nextCycle(); applyStimulus(0, 0, 32'h0, 32'h0, 16'h0);
        checkOutput("a4.c10.ready", 32'(ready4), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- MEM-stage data-memory controller; the upstream producer of the memory read result and the Freeze signal consumed by the MEM/WB pipeline register.
- Converts one 32-bit pipeline load/store into two timed 16-bit external SRAM accesses, low half first.
- Holds the pipeline frozen until the access completes.

Parameters:
- ACCESS_CYCLES, 2, cycles each half-word access holds SRAM address/control stable; legal range 2..15.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  store request from MEM stage; held stable while freeze=1.
- rd_en  in  1  load request from MEM stage; held stable while freeze=1.
- address  in  32  byte address; only bits [SRAM_AW:2] used.
- write_data  in  32  store data.
- read_data  out  32  load result; valid when ready=1, held until next load completes.
- ready  out  1  access complete; one-cycle pulse.
- freeze  out  1  stall to IF/ID/EX/MEM pipeline registers.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_oe  out  1  pad output enable for sram_dq_out.
- sram_dq_in  in  16  data from SRAM pads.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, read_data=0, ready=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, counter=0.
  - Reset mid-access aborts it; sram_we_n rises at once, and a partial write is not completed.
- freeze = (rd_en | wr_en) & ~ready. This is combinational, so there is no freeze when no request is present.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE: on rd_en or wr_en, latch address, write_data and op, then go to LOW with counter=0. If both are asserted, write wins and rd_en is ignored.
  - LOW: sram_addr = {address[SRAM_AW:2], 1'b0}. Counter increments each cycle. At counter = ACCESS_CYCLES-1, go to HIGH and reset the counter.
  - HIGH: sram_addr = {address[SRAM_AW:2], 1'b1}. Same counting as LOW. At the last cycle, go to DONE.
  - DONE: ready=1 for exactly one cycle, then go to IDLE unconditionally. A request still asserted during DONE is the same instruction (the pipeline advances on this edge) and is not restarted.
- Write phases:
  - sram_dq_oe=1 throughout LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - sram_we_n=0 for counter 0..ACCESS_CYCLES-2 and 1 on the last cycle of each phase, so address changes only while WE is high.
- Read phases:
  - sram_we_n=1 and sram_dq_oe=0.
  - sram_dq_in is sampled on the last cycle of each phase into read_data[15:0] (LOW) and read_data[31:16] (HIGH).
  - read_data updates only on loads; stores leave it unchanged.
- Latency: request seen in IDLE at cycle 0 gives ready at cycle 2*ACCESS_CYCLES+1. Freeze is high for cycles 0..2*ACCESS_CYCLES.
- Request deasserted mid-access (illegal under the freeze contract): the access completes anyway.
- Outputs sram_* are registered (driven from state/counter flops); no combinational path from inputs to sram_*.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum {IDLE, LOW, HIGH, DONE}.
  - Half-select constants LOW_HALF=0, HIGH_HALF=1.
  - Default ACCESS_CYCLES.
- One sub-module, sram_access_timer:
  - Counter with start/clear inputs and last_cycle/phase_done outputs, parameterised by ACCESS_CYCLES.
  - Instantiated once.

Test Plan:
- Reset: assert rst mid-write (LOW, counter=0) -> same cycle sram_we_n=1, sram_dq_oe=0, ready=0, read_data=0; after release state is IDLE and freeze equals the request.
- Store (ACCESS_CYCLES=2): wr_en=1, address=0x100, write_data=0xDEADBEEF ->
  - sram_addr=0x080, dq_out=0xBEEF, we_n pattern 0,1.
  - Then sram_addr=0x081, dq_out=0xDEAD, we_n pattern 0,1.
  - ready=1 at cycle 5; freeze=1 for cycles 0..4.
- Load: rd_en=1, address=0x100, sram_dq_in=0x1234 on the LOW last cycle and 0xABCD on the HIGH last cycle -> read_data=0xABCD1234 with ready at cycle 5; we_n stays 1 and dq_oe stays 0 throughout.
- Simultaneous wr_en=1 and rd_en=1 -> write sequence performed and read_data unchanged.
- Back-to-back: load held through DONE, then a new store presented the next cycle -> no re-issue of the load; store starts in the following IDLE cycle.
- ACCESS_CYCLES=4 load: ready at cycle 9, and each half is sampled only on its 4th cycle (changing dq_in on earlier cycles has no effect).
